// File: rtl/interval_timer_sched_pkg.sv
// Shared definitions for the interval timer scheduler.
//   state_t : scheduler FSM states (IDLE/LOAD/COUNT/DONE)
//   clog2   : index width helper, never returns less than 1
package timer_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/interval_timer_sched_if.sv
// Request/service bundle between the requesting control FSMs and the shared timer.
//   req       : per-requester request level
//   dur       : packed durations, requester i at dur[i*N +: N]
//   tick      : count-enable strobe
//   abort     : abort of the current service
//   gnt       : one-hot grant of the served requester
//   done_tick : one-cycle expiry pulse to the served requester
//   busy      : timer not idle
//   cnt       : current timer value
// master = requester side, slave = timer side.
interface interval_timer_sched_if #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
);
  logic [R-1:0]   req;
  logic [R*N-1:0] dur;
  logic           tick;
  logic           abort;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done_tick;
  logic           busy;
  logic [N-1:0]   cnt;

  modport master (
    output req, dur, tick, abort,
    input  gnt, done_tick, busy, cnt
  );

  modport slave (
    input  req, dur, tick, abort,
    output gnt, done_tick, busy, cnt
  );
endinterface

// File: rtl/interval_timer_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index for this search
//   any : some request is pending
//   idx : winning index (first requester at or after ptr, wrapping R-1 -> 0)
//   win : one-hot form of idx
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter  int unsigned R  = 4,
  localparam int unsigned IW = clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [R-1:0]  win
);

  localparam int unsigned  PW = IW + 1;
  localparam logic [IW:0]  RW = PW'(R);

  logic [IW:0]   pos;
  logic [IW-1:0] sel;

  // Walk R positions starting at ptr; one conditional subtract wraps the
  // sum since ptr + k never reaches 2R.
  always_comb begin
    any = 1'b0;
    idx = '0;
    win = '0;
    pos = '0;
    sel = '0;
    for (int unsigned k = 0; k < R; k++) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= RW) pos = pos - RW;
      sel = pos[IW-1:0];
      if (!any && req[sel]) begin
        any      = 1'b1;
        idx      = sel;
        win[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_timer_sched.sv
// Shares one N-bit down-counting interval timer between R requesters.
// A round-robin arbiter picks a requester; the FSM loads its duration,
// counts down on tick, pulses its done_tick and re-arbitrates.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of interval_timer_sched_if (req/dur/tick/abort in,
//             gnt/done_tick/busy/cnt out); all outputs registered except busy
module interval_timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  interval_timer_sched_if.slave  bus
);

  localparam int unsigned IW = clog2(R);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [R-1:0]  gnt_q, gnt_d;
  logic [R-1:0]  done_q, done_d;

  logic          arb_any;
  logic [IW-1:0] arb_idx;
  logic [R-1:0]  arb_win;
  logic [IW-1:0] ptr_next;
  logic [N-1:0]  dur_sel;
  logic          drop;

  rr_arbiter #(.R(R)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .any (arb_any),
    .idx (arb_idx),
    .win (arb_win)
  );

  assign ptr_next = (idx_q == IW'(R - 1)) ? '0 : idx_q + IW'(1);
  assign dur_sel  = bus.dur[32'(idx_q) * N +: N];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    drop    = bus.abort || !bus.req[idx_q];
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          idx_d   = arb_idx;
          gnt_d   = arb_win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (drop) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else begin
          cnt_d   = dur_sel;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        // Withdrawal/abort is tested before expiry so it wins a tie.
        if (drop) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          done_d  = gnt_q;
          state_d = S_DONE;
        end else if (bus.tick) begin
          cnt_d   = cnt_q - N'(1);
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done_tick = done_q;
  assign bus.cnt       = cnt_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
